mem_arbiter: RTL

Parametrised single-port memory arbiter for the MIPS CPU wrapper. It replaces the separate instruction ROM and data RAM with one unified synchronous RAM that both the fetch port and the load/store port of `mips_core` share. It arbitrates between the two ports, inserts wait states for a configurable RAM read latency, drives per-port stall signals back to the core, and flags out-of-range accesses.

---
 rtl/mem_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous RAM between the fetch port and the load/store port.
// Optional build macro MEM_ARB_STATS_EN adds the conflict_cnt / stall_cnt statistics ports.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 1,
  localparam int unsigned BE_W       = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inst_ren,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic                  inst_stall,
  output logic                  inst_err,
  input  logic                  mem_ren,
  input  logic                  mem_wen,
  input  logic [BE_W-1:0]       mem_be,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_din,
  output logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  mem_stall,
  output logic                  mem_err,
  output logic                  ram_en,
  output logic [BE_W-1:0]       ram_we,
  output logic [DEPTH_LOG2-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]           conflict_cnt,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned HI_LSB = DEPTH_LOG2 + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_D = 2'd1,
    RD_I = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic [DATA_WIDTH-1:0] mem_q, mem_d;

  logic mem_req;
  logic mem_oor;
  logic inst_oor;
  logic done;
  logic unused_lsb;

  assign mem_req    = mem_ren | mem_wen;
  assign mem_oor    = (mem_addr >> HI_LSB) != '0;
  assign inst_oor   = (inst_addr >> HI_LSB) != '0;
  assign done       = (cnt_q == CNT_W'(1));
  assign unused_lsb = ^{inst_addr[1:0], mem_addr[1:0]};

  // Arbitration, wait-state sequencing and combinational port/RAM outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    inst_d     = inst_q;
    mem_d      = mem_q;
    ram_en     = 1'b0;
    ram_we     = '0;
    ram_addr   = '0;
    ram_wdata  = '0;
    inst_data  = inst_q;
    inst_stall = 1'b0;
    inst_err   = 1'b0;
    mem_dout   = mem_q;
    mem_stall  = 1'b0;
    mem_err    = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_req) begin
          inst_stall = inst_ren;
          if (mem_oor) begin
            mem_err  = 1'b1;
            mem_dout = '0;
            if (!mem_wen) mem_d = '0;
          end else if (mem_wen) begin
            ram_en    = 1'b1;
            ram_we    = mem_be;
            ram_addr  = mem_addr[DEPTH_LOG2+1:2];
            ram_wdata = mem_din;
          end else begin
            ram_en    = 1'b1;
            ram_addr  = mem_addr[DEPTH_LOG2+1:2];
            mem_stall = 1'b1;
            cnt_d     = CNT_W'(WAIT_CYCLES);
            state_d   = RD_D;
          end
        end else if (inst_ren) begin
          if (inst_oor) begin
            inst_err  = 1'b1;
            inst_data = '0;
            inst_d    = '0;
          end else begin
            ram_en     = 1'b1;
            ram_addr   = inst_addr[DEPTH_LOG2+1:2];
            inst_stall = 1'b1;
            cnt_d      = CNT_W'(WAIT_CYCLES);
            state_d    = RD_I;
          end
        end
      end

      RD_D: begin
        cnt_d      = cnt_q - CNT_W'(1);
        inst_stall = inst_ren;
        if (done) begin
          mem_dout = ram_rdata;
          mem_d    = ram_rdata;
          state_d  = IDLE;
        end else begin
          mem_stall = 1'b1;
        end
      end

      RD_I: begin
        cnt_d     = cnt_q - CNT_W'(1);
        mem_stall = mem_req;
        if (done) begin
          inst_data = ram_rdata;
          inst_d    = ram_rdata;
          state_d   = IDLE;
        end else begin
          inst_stall = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Reset forces every output low immediately, even with requests pending
    if (!rst_n) begin
      ram_en     = 1'b0;
      ram_we     = '0;
      ram_addr   = '0;
      ram_wdata  = '0;
      inst_data  = '0;
      inst_stall = 1'b0;
      inst_err   = 1'b0;
      mem_dout   = '0;
      mem_stall  = 1'b0;
      mem_err    = 1'b0;
    end
  end

  // State, wait counter and per-port read-data holding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      inst_q  <= '0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inst_q  <= inst_d;
      mem_q   <= mem_d;
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic conflict;

  // A fetch is unserved whenever both ports request outside a fetch access
  assign conflict = inst_ren & mem_req & (state_q != RD_I);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (conflict && (conflict_cnt != '1)) conflict_cnt <= conflict_cnt + 32'd1;
      if ((inst_stall | mem_stall) && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  // Statistics hardware is absent in this build.
`endif

endmodule
